// File: rtl/bram_pkg.sv
// Shared constants and helpers for the BRAM port controller.
// Optional statistics counters are enabled with BRAM_CTRL_STATS_EN.
package bram_pkg;

    localparam int RSP_BUF_DEPTH = 2;
    localparam int STAT_WIDTH    = 16;
    localparam int CNT_WIDTH     = $clog2(RSP_BUF_DEPTH + 1);

    function automatic logic [STAT_WIDTH-1:0] sat_inc(
        input logic [STAT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rsp_fifo2.sv
// Two-entry response FIFO: head register feeds the consumer,
// tail register absorbs one extra response while the head is stalled.
module rsp_fifo2
    import bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CNT_WIDTH-1:0]  count_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(RSP_BUF_DEPTH);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [CNT_WIDTH-1:0]  count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (count_q < FULL) begin
                        if (count_q == '0) head_q <= data_i;
                        else               tail_q <= data_i;
                        count_q <= count_q + 1'b1;
                    end
                end
                2'b01: begin
                    if (count_q != '0) begin
                        head_q  <= tail_q;
                        count_q <= count_q - 1'b1;
                    end
                end
                2'b11: begin
                    // Simultaneous capture and pop keeps occupancy unchanged.
                    if (count_q == FULL) begin
                        head_q <= tail_q;
                        tail_q <= data_i;
                    end else begin
                        head_q <= data_i;
                        if (count_q == '0) count_q <= count_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign count_o = count_q;
    assign head_o  = head_q;

endmodule

// File: rtl/bram_port_ctrl.sv
// Valid/ready front end for a single-port BRAM with fixed read latency 2.
// Define BRAM_CTRL_STATS_EN to add saturating wr_cnt_o / rd_cnt_o.
module bram_port_ctrl
    import bram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int BRAM_DEPTH = 128,
    localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_wr_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  bram_cmd_en_o,
    output logic                  bram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i
`ifdef BRAM_CTRL_STATS_EN
   ,output logic [STAT_WIDTH-1:0] wr_cnt_o,
    output logic [STAT_WIDTH-1:0] rd_cnt_o
`endif
);

    logic                 pend_q;
    logic [CNT_WIDTH-1:0] count;
    logic [2:0]           inflight;
    logic                 pop;
    logic                 rd_ok;
    logic                 accept;
    logic                 wr_acc;
    logic                 rd_acc;

    assign rsp_valid_o = !rst_i && (count != '0);
    assign pop         = rsp_valid_o & rsp_ready_i;

    // Credit: in-flight plus buffered reads, less this cycle's pop, below 2.
    assign inflight = 3'({1'b0, count}) + {2'b00, pend_q};
    assign rd_ok    = inflight < (3'd2 + {2'b00, pop});

    assign req_ready_o = !rst_i && (req_wr_i || rd_ok);
    assign accept      = req_valid_i & req_ready_o;
    assign wr_acc      = accept & req_wr_i;
    assign rd_acc      = accept & ~req_wr_i;

    assign bram_cmd_en_o = accept;
    assign bram_wr_en_o  = wr_acc;
    assign bram_addr_o   = req_addr_i;
    assign bram_data_o   = req_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) pend_q <= 1'b0;
        else       pend_q <= rd_acc;
    end

    rsp_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pend_q),
        .pop_i   (pop),
        .data_i  (bram_data_i),
        .count_o (count),
        .head_o  (rsp_data_o)
    );

`ifdef BRAM_CTRL_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_cnt_o <= '0;
            rd_cnt_o <= '0;
        end else begin
            if (wr_acc) wr_cnt_o <= sat_inc(wr_cnt_o);
            if (rd_acc) rd_cnt_o <= sat_inc(rd_cnt_o);
        end
    end
`endif

endmodule

// File: tb/tb_bram_port_ctrl.sv
// Randomized bench for bram_port_ctrl against a queue-based reference model.
// Define BRAM_CTRL_STATS_EN to also exercise the statistics counters.
module tb_bram_port_ctrl;

    localparam int DW = 32;
    localparam int DEPTH = 128;
    localparam int AW = $clog2(DEPTH);

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_wr_i;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_data_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [DW-1:0] rsp_data_o;
    logic          bram_cmd_en_o;
    logic          bram_wr_en_o;
    logic [AW-1:0] bram_addr_o;
    logic [DW-1:0] bram_data_o;
    logic [DW-1:0] bram_data_i;
`ifdef BRAM_CTRL_STATS_EN
    logic [15:0]   wr_cnt_o;
    logic [15:0]   rd_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    bram_port_ctrl #(
        .DATA_WIDTH (DW),
        .BRAM_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_wr_i      (req_wr_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .rsp_data_o    (rsp_data_o),
        .bram_cmd_en_o (bram_cmd_en_o),
        .bram_wr_en_o  (bram_wr_en_o),
        .bram_addr_o   (bram_addr_o),
        .bram_data_o   (bram_data_o),
        .bram_data_i   (bram_data_i)
`ifdef BRAM_CTRL_STATS_EN
       ,.wr_cnt_o      (wr_cnt_o),
        .rd_cnt_o      (rd_cnt_o)
`endif
    );

    // Attached BRAM: registered read output, one cycle after the command.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk_i) begin
        if (bram_cmd_en_o) begin
            if (bram_wr_en_o) mem[bram_addr_o] <= bram_data_o;
            else              bram_data_i <= mem[bram_addr_o];
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    logic [DW-1:0] ref_mem [DEPTH];
    exp_t          q[$];
    int            cyc;
    int            n_chk;
    int            n_pass;
    int            wr_n;
    int            rd_n;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic step(input logic rst, input logic v, input logic wr,
                        input int a, input logic [DW-1:0] d,
                        input logic rr);
        logic ev;
        logic epop;
        logic erdy;
        logic eacc;
        rst_i       = rst;
        req_valid_i = v;
        req_wr_i    = wr;
        req_addr_i  = AW'(a);
        req_data_i  = d;
        rsp_ready_i = rr;
        @(negedge clk_i);
        if (rst) begin
            ev   = 1'b0;
            erdy = 1'b0;
        end else begin
            ev   = (q.size() > 0) && (q[0].due <= cyc);
            erdy = wr || ((q.size() - int'(ev && rr)) < 2);
        end
        epop = ev & rr;
        eacc = v & erdy;
        check("req_ready", {31'b0, req_ready_o}, {31'b0, erdy});
        check("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, ev});
        if (ev) check("rsp_data", rsp_data_o, q[0].data);
        check("cmd_en", {31'b0, bram_cmd_en_o}, {31'b0, eacc});
        check("wr_en", {31'b0, bram_wr_en_o}, {31'b0, eacc & wr});
        if (eacc) check("bram_addr", {25'b0, bram_addr_o}, DW'(a));
`ifdef BRAM_CTRL_STATS_EN
        check("wr_cnt", {16'b0, wr_cnt_o}, DW'(wr_n));
        check("rd_cnt", {16'b0, rd_cnt_o}, DW'(rd_n));
`endif
        if (rst) begin
            q.delete();
            wr_n = 0;
            rd_n = 0;
        end else begin
            if (epop) void'(q.pop_front());
            if (eacc && wr) begin
                ref_mem[a] = d;
                if (wr_n < 16'hFFFF) wr_n++;
            end
            if (eacc && !wr) begin
                q.push_back('{data: ref_mem[a], due: cyc + 2});
                if (rd_n < 16'hFFFF) rd_n++;
            end
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 0, '0, rr);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        wr_n   = 0;
        rd_n   = 0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = DW'(i);
            ref_mem[i] = DW'(i);
        end
        bram_data_i = '0;

        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0, '0, 1'b1);
        check("rsp_data_rst", rsp_data_o, '0);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, i, '0, 1'b1);
        idle(4, 1'b1);

        step(1'b0, 1'b1, 1'b1, 5, 32'hDEADBEEF, 1'b1);
        step(1'b0, 1'b1, 1'b0, 5, '0, 1'b1);
        idle(4, 1'b1);

        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 10 + i, '0, 1'b0);
        check("stall_depth", DW'(q.size()), DW'(2));
        step(1'b0, 1'b1, 1'b1, 40, 32'h0000_4040, 1'b0);
        step(1'b0, 1'b1, 1'b1, 41, 32'h0000_4141, 1'b0);
        idle(3, 1'b0);
        idle(4, 1'b1);

        step(1'b0, 1'b1, 1'b1, 3, 32'h11, 1'b1);
        step(1'b0, 1'b1, 1'b0, 3, '0, 1'b1);
        idle(4, 1'b1);

        step(1'b0, 1'b1, 1'b0, 20, '0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 0, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 21, '0, 1'b0);
        idle(5, 1'b0);
        idle(3, 1'b1);

        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) == 0, int'($urandom_range(0, DEPTH - 1)),
                 $urandom, $urandom_range(0, 3) != 0);
        end
        idle(6, 1'b1);

`ifdef BRAM_CTRL_STATS_EN
        for (int i = 0; i < 70000; i++)
            step(1'b0, 1'b1, 1'b0, i % DEPTH, '0, 1'b1);
        idle(4, 1'b1);
        check("rd_cnt_sat", {16'b0, rd_cnt_o}, 32'h0000_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bram_port_ctrl.md
BRAM_PORT_CTRL -- requirements
Module: bram_port_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter BRAM_DEPTH, default 128, words in attached BRAM.
REQ-003 SHALL derive localparam ADDR_WIDTH = $clog2(BRAM_DEPTH).
REQ-004 SHALL use one clock and a synchronous, active-high reset, with ports clk_i and rst_i.
REQ-005 SHALL have port clk_i  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-007 SHALL have port req_valid_i  in  1  request present.
REQ-008 SHALL have port req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-009 SHALL have port req_wr_i  in  1  1 = write, 0 = read.
REQ-010 SHALL have port req_addr_i  in  ADDR_WIDTH  word address.
REQ-011 SHALL have port req_data_i  in  DATA_WIDTH  write data.
REQ-012 SHALL have port rsp_valid_o  out  1  read data available.
REQ-013 SHALL have port rsp_ready_i  in  1  consumer takes read data.
REQ-014 SHALL have port rsp_data_o  out  DATA_WIDTH  read data.
REQ-015 SHALL have ports bram_cmd_en_o, bram_wr_en_o (out 1), bram_addr_o (out ADDR_WIDTH) and bram_data_o (out DATA_WIDTH), driving the BRAM command port.
REQ-016 SHALL have port bram_data_i  in  DATA_WIDTH  BRAM registered read output, valid one cycle after the read command.

Function
REQ-017 SHALL define acceptance as req_valid_i & req_ready_o in the same cycle.
REQ-018 SHALL drive bram_cmd_en_o = acceptance, bram_wr_en_o = req_wr_i & acceptance, and pass addr/data through combinationally.
REQ-019 SHALL hold req_ready_o high for writes whenever not in reset; writes never consume credit.
REQ-020 SHALL, for reads, assert req_ready_o only when (pend + count - pop) < 2. pend is the 1-bit in-flight flag, count is the buffer occupancy (0..2), and pop = rsp_valid_o & rsp_ready_i.
REQ-021 SHALL set pend on the edge ending a read acceptance cycle T; at the end of T+1 it captures bram_data_i into the buffer and clears pend, unless a new read is also accepted in T+1.
REQ-022 SHALL assert rsp_valid_o exactly 2 cycles after read acceptance when the buffer was empty; the fixed read latency is 2.
REQ-023 SHALL return responses strictly in request order.
REQ-024 SHALL hold rsp_data_o stable while rsp_valid_o & !rsp_ready_i.
REQ-025 SHALL sustain one read per cycle while rsp_ready_i stays high.
REQ-026 SHALL handle capture and pop in the same cycle: count unchanged, order preserved.
REQ-027 SHALL never overflow the buffer; a read at count = 2 with no pop is not accepted.
REQ-028 SHALL return new data for a write at T followed by a read of the same address at T+1.
REQ-029 SHALL forward addresses >= BRAM_DEPTH unchanged; such addresses are illegal stimulus.

Reset
REQ-030 SHALL force, while rst_i is high: req_ready_o = 0, bram_cmd_en_o = 0, bram_wr_en_o = 0, rsp_valid_o = 0.
REQ-031 SHALL clear pend and count on reset and drop any in-flight or buffered data, including mid-operation.
REQ-032 SHALL reset rsp_data_o to 0.

Configuration
REQ-033 SHALL add, with BRAM_CTRL_STATS_EN defined, outputs wr_cnt_o and rd_cnt_o (16 bits each).
REQ-034 SHALL increment those counters on write/read acceptance, saturate at 0xFFFF, and reset to 0.
REQ-035 SHALL omit both ports and the counter logic when BRAM_CTRL_STATS_EN is undefined; all other behaviour is identical.

Structure
REQ-036 SHALL place constants RSP_BUF_DEPTH = 2 and STAT_WIDTH = 16 in shared package bram_pkg.
REQ-037 SHALL implement the response buffer as sub-module rsp_fifo2 (2-entry FIFO: push, pop, count, head data).
REQ-038 SHALL contain no memory array; storage is the external BRAM.

Verification
REQ-039 SHALL cover: write 0xDEADBEEF @5, then read @5 with rsp_ready_i = 1 -> rsp_valid_o 2 cycles later, data 0xDEADBEEF.
REQ-040 SHALL cover: reads @0..7 back-to-back (mem[i] = i), rsp_ready_i = 1 -> 8 consecutive responses 0..7, req_ready_o never low.
REQ-041 SHALL cover: rsp_ready_i = 0, 4 reads requested -> exactly 2 accepted, count = 2; writes still accepted; on release, 2 responses drain in order.
REQ-042 SHALL cover: rst_i asserted the cycle after a read is accepted -> no response ever appears; after reset, ready within 1 cycle.
REQ-043 SHALL cover: write @3 = 0x11 at T, read @3 at T+1 -> 0x11.
REQ-044 SHALL cover: with BRAM_CTRL_STATS_EN, 70000 reads -> rd_cnt_o = 0xFFFF.
